// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage of the 16-bit single-issue core. Owns the PC,
//   presents it to instruction memory, and registers the fetched word together
//   with its PC for the decode stage. Branch redirects from execute flush the
//   output register and load br_pc + 1 + br_offset. A halt opcode parks the
//   stage in HALT until the next redirect.
//
//   Optional feature: define FETCH_PERF_EN to add the perf_fetched and
//   perf_bubbles saturating 32-bit counters (and their output ports).
//
// Ports
//   clk          in   1        clock, rising edge
//   reset        in   1        synchronous, active-low reset
//   imem_addr    out  PC_W     instruction-memory address (= pc)
//   imem_rdata   in   INSTR_W  instruction word at imem_addr (combinational)
//   id_ready     in   1        decode accepts if_instr this cycle
//   br_taken     in   1        redirect request from execute
//   br_pc        in   PC_W     PC of the redirecting branch
//   br_offset    in   PC_W     sign-extended branch offset
//   if_valid     out  1        if_instr/if_pc hold a valid instruction
//   if_instr     out  INSTR_W  registered instruction to decode
//   if_pc        out  PC_W     PC of if_instr
//   halted       out  1        fetch is in HALT state
//   perf_fetched out  32       (FETCH_PERF_EN) instructions fetched
//   perf_bubbles out  32       (FETCH_PERF_EN) cycles with if_valid low
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int               PC_W     = 16,
  parameter int               INSTR_W  = 16,
  parameter logic [PC_W-1:0]  RESET_PC = '0,
  parameter logic [3:0]       HALT_OPC = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               id_ready,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_pc,
  input  logic [PC_W-1:0]    br_offset,
  output logic               if_valid,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc,
  output logic               halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_HALT = 1'b1;

  logic            state;
  logic [PC_W-1:0] pc;

  logic            accept;
  logic            fetch;
  logic            is_halt_opc;
  logic [PC_W-1:0] br_target;

  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  // The output register can take a new word when it is empty or being drained.
  assign accept      = !if_valid || id_ready;
  assign fetch       = (state == ST_RUN) && accept;
  assign is_halt_opc = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPC);

  // Branch target is relative to the instruction after the branch; wraps mod 2^PC_W.
  assign br_target = br_pc + br_offset + PC_W'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; the reset is sampled on the clock edge only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc       <= RESET_PC;
      state    <= ST_RUN;
      if_valid <= 1'b0;
      if_instr <= '0;
      if_pc    <= '0;
    end else if (br_taken) begin
      // Flush: one bubble, the target is fetched on the following cycle.
      pc       <= br_target;
      if_valid <= 1'b0;
      state    <= ST_RUN;
    end else if (state == ST_RUN) begin
      if (accept) begin
        if_instr <= imem_rdata;
        if_pc    <= pc;
        if_valid <= 1'b1;
        if (is_halt_opc) begin
          state <= ST_HALT;
        end else begin
          pc <= pc + PC_W'(1);
        end
      end
    end else begin
      // HALT: no further fetches; let decode drain the last word.
      if (id_ready) begin
        if_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (fetch && !br_taken && (perf_fetched != 32'hFFFF_FFFF)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (!if_valid && (perf_bubbles != 32'hFFFF_FFFF)) begin
        perf_bubbles <= perf_bubbles + 32'd1;
      end
    end
  end
`else
  // fetch only feeds the performance counters.
  logic unused_fetch;
  assign unused_fetch = fetch;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Self-checking bench for fetch_unit. Each record holds the inputs for one
//   cycle plus the outputs expected right after that cycle's rising edge.
//   The driver applies a record on the falling edge and queues it; the
//   checker pops it just after the next rising edge and compares.
//   Instruction memory: word at address a is 16'h1000 + a, except that when
//   halt_en is set the word at address 3 is the halt instruction 16'hF000.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  typedef struct {
    logic        rst_n;
    logic        idr;
    logic        br;
    logic [15:0] bpc;
    logic [15:0] boff;
    logic        hen;
    logic        e_valid;
    logic        chk;      // compare if_pc / if_instr
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_addr;
    logic        e_halt;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        id_ready;
  logic        br_taken;
  logic [15:0] br_pc;
  logic [15:0] br_offset;
  logic        if_valid;
  logic [15:0] if_instr;
  logic [15:0] if_pc;
  logic        halted;
  logic        halt_en;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int   checks = 0;
  int   errors = 0;
  vec_t exp_q[$];
  vec_t vecs[$];

  fetch_unit dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .id_ready   (id_ready),
    .br_taken   (br_taken),
    .br_pc      (br_pc),
    .br_offset  (br_offset),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .halted     (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_bubbles (perf_bubbles)
`endif
  );

  assign imem_rdata = (halt_en && imem_addr == 16'd3) ? 16'hF000 : 16'h1000 + imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic r, input logic idr, input logic br,
                             input logic [15:0] bpc, input logic [15:0] boff,
                             input logic hen, input logic ev, input logic chk,
                             input logic [15:0] epc, input logic [15:0] einstr,
                             input logic [15:0] eaddr, input logic eh);
    vec_t t;
    t = '{r, idr, br, bpc, boff, hen, ev, chk, epc, einstr, eaddr, eh};
    return t;
  endfunction

  task automatic drive(input vec_t t);
    @(negedge clk);
    reset     = t.rst_n;
    id_ready  = t.idr;
    br_taken  = t.br;
    br_pc     = t.bpc;
    br_offset = t.boff;
    halt_en   = t.hen;
    exp_q.push_back(t);
  endtask

  // Checker: compares the record queued for the edge that just happened.
  initial begin
    int   n;
    vec_t t;
    n = 0;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        t = exp_q.pop_front();
        check($sformatf("v%0d if_valid", n), 32'(if_valid), 32'(t.e_valid));
        check($sformatf("v%0d imem_addr", n), 32'(imem_addr), 32'(t.e_addr));
        check($sformatf("v%0d halted", n), 32'(halted), 32'(t.e_halt));
        if (t.chk) begin
          check($sformatf("v%0d if_pc", n), 32'(if_pc), 32'(t.e_pc));
          check($sformatf("v%0d if_instr", n), 32'(if_instr), 32'(t.e_instr));
        end
`ifdef FETCH_PERF_EN
        if (!t.rst_n) begin
          check($sformatf("v%0d perf_fetched", n), perf_fetched, 32'd0);
          check($sformatf("v%0d perf_bubbles", n), perf_bubbles, 32'd0);
        end
`endif
        n++;
      end
    end
  end

  initial begin
    reset     = 1'b0;
    id_ready  = 1'b1;
    br_taken  = 1'b0;
    br_pc     = '0;
    br_offset = '0;
    halt_en   = 1'b0;

    // Reset for two cycles, then streaming at one instruction per cycle.
    vecs.push_back(v(0,1,0,16'h0,16'h0,0, 0,1,16'h0,16'h0,16'h0,0));
    vecs.push_back(v(0,1,0,16'h0,16'h0,0, 0,1,16'h0,16'h0,16'h0,0));
    for (int p = 0; p <= 5; p++)
      vecs.push_back(v(1,1,0,16'h0,16'h0,0, 1,1,16'(p),16'h1000 + 16'(p),16'(p + 1),0));
    // Back-pressure holds everything with if_pc=5.
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1,0,0,16'h0,16'h0,0, 1,1,16'h5,16'h1005,16'h6,0));
    vecs.push_back(v(1,1,0,16'h0,16'h0,0, 1,1,16'h6,16'h1006,16'h7,0));
    // Redirect to 8+1-4 = 5 while decode stalls: flush still happens.
    vecs.push_back(v(1,0,1,16'h8,16'hFFFC,0, 0,0,16'h0,16'h0,16'h5,0));
    vecs.push_back(v(1,0,0,16'h0,16'h0,0, 1,1,16'h5,16'h1005,16'h6,0));
    vecs.push_back(v(1,1,0,16'h0,16'h0,0, 1,1,16'h6,16'h1006,16'h7,0));
    // Forward redirect 8+1+2 = 11 with decode ready.
    vecs.push_back(v(1,1,1,16'h8,16'h2,0, 0,0,16'h0,16'h0,16'hB,0));
    vecs.push_back(v(1,1,0,16'h0,16'h0,0, 1,1,16'hB,16'h100B,16'hC,0));
    // Halt opcode at address 3.
    vecs.push_back(v(1,1,1,16'h0,16'h1,1, 0,0,16'h0,16'h0,16'h2,0));
    vecs.push_back(v(1,1,0,16'h0,16'h0,1, 1,1,16'h2,16'h1002,16'h3,0));
    vecs.push_back(v(1,1,0,16'h0,16'h0,1, 1,1,16'h3,16'hF000,16'h3,1));
    vecs.push_back(v(1,0,0,16'h0,16'h0,1, 1,1,16'h3,16'hF000,16'h3,1));
    for (int i = 0; i < 3; i++)
      vecs.push_back(v(1,1,0,16'h0,16'h0,1, 0,0,16'h0,16'h0,16'h3,1));
    vecs.push_back(v(1,1,1,16'h0,16'h0,1, 0,0,16'h0,16'h0,16'h1,0));
    vecs.push_back(v(1,1,0,16'h0,16'h0,0, 1,1,16'h1,16'h1001,16'h2,0));
    // PC wrap: redirect to FFFF, then 0000.
    vecs.push_back(v(1,1,1,16'hFFFE,16'h0,0, 0,0,16'h0,16'h0,16'hFFFF,0));
    vecs.push_back(v(1,1,0,16'h0,16'h0,0, 1,1,16'hFFFF,16'h0FFF,16'h0,0));
    vecs.push_back(v(1,1,0,16'h0,16'h0,0, 1,1,16'h0,16'h1000,16'h1,0));

    foreach (vecs[i]) drive(vecs[i]);

    // Reset while stalled with a valid word.
    drive(v(1,0,0,16'h0,16'h0,0, 1,1,16'h0,16'h1000,16'h1,0));
    drive(v(0,0,0,16'h0,16'h0,0, 0,1,16'h0,16'h0,16'h0,0));

    // Reset while halted overrides a simultaneous redirect.
    drive(v(1,1,0,16'h0,16'h0,1, 1,1,16'h0,16'h1000,16'h1,0));
    drive(v(1,1,0,16'h0,16'h0,1, 1,1,16'h1,16'h1001,16'h2,0));
    drive(v(1,1,0,16'h0,16'h0,1, 1,1,16'h2,16'h1002,16'h3,0));
    drive(v(1,1,0,16'h0,16'h0,1, 1,1,16'h3,16'hF000,16'h3,1));
    drive(v(0,1,1,16'hFFFE,16'h0,1, 0,1,16'h0,16'h0,16'h0,0));
    drive(v(1,1,0,16'h0,16'h0,0, 1,1,16'h0,16'h1000,16'h1,0));

    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
